// File: rtl/parity_frame_ctrl.sv
// rtl/parity_frame_ctrl.sv - word-to-serial frame sequencer with appended even/odd parity bit
module parity_frame_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             odd_sel,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    cnt;
    logic             acc;
    logic             ser_out_q;
    logic             ser_valid_q;
    logic             ser_last_q;
    logic             accept;
    logic             beat;

    // A new word can enter from idle, or on the edge that consumes the parity beat.
    assign in_ready  = (state == IDLE) || ((state == PARITY) && ser_ready);
    assign accept    = in_valid && in_ready;
    assign beat      = ser_valid_q && ser_ready;

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_last  = ser_last_q;
    assign busy      = (state != IDLE);

    // Frame sequencer: the serial outputs are registered alongside the state,
    // so the next bit to present is computed here from the current datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            acc         <= 1'b0;
            frame_cnt   <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg       <= in_data;
                        acc         <= odd_sel;
                        cnt         <= '0;
                        state       <= DATA;
                        ser_out_q   <= in_data[0];
                        ser_valid_q <= 1'b1;
                        ser_last_q  <= 1'b0;
                    end
                end
                DATA: begin
                    if (beat) begin
                        shreg <= shreg >> 1;
                        acc   <= acc ^ shreg[0];
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST_BIT) begin
                            // Parity bit includes the data bit being consumed now.
                            state      <= PARITY;
                            ser_out_q  <= acc ^ shreg[0];
                            ser_last_q <= 1'b1;
                        end else begin
                            ser_out_q <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (beat) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        if (in_valid) begin
                            shreg       <= in_data;
                            acc         <= odd_sel;
                            cnt         <= '0;
                            state       <= DATA;
                            ser_out_q   <= in_data[0];
                            ser_valid_q <= 1'b1;
                            ser_last_q  <= 1'b0;
                        end else begin
                            state       <= IDLE;
                            ser_out_q   <= 1'b0;
                            ser_valid_q <= 1'b0;
                            ser_last_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    ser_out_q   <= 1'b0;
                    ser_valid_q <= 1'b0;
                    ser_last_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// tb/tb_parity_frame_ctrl.sv - directed self-checking bench for parity_frame_ctrl
module tb_parity_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       odd_sel;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;
    logic       ser_ready;
    logic       busy;
    logic [3:0] frame_cnt;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] exp_cnt;

    parity_frame_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .odd_sel   (odd_sel),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .ser_ready (ser_ready),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(ser_valid), 32'd0);
        check({tag, "_out"},   32'(ser_out),   32'd0);
        check({tag, "_last"},  32'(ser_last),  32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_ready"}, 32'(in_ready),  32'd1);
        check({tag, "_cnt"},   32'(frame_cnt), 32'd0);
    endtask

    // One frame: accept word d, then observe WIDTH+1 beats; optional stalls
    // of st_len cycles at data bit st_bit and par_len cycles at the parity beat.
    task automatic run_frame(input logic [7:0] d, input logic odd, input logic par,
                             input int st_bit, input int st_len, input int par_len);
        logic [8:0] bits;
        int         stall;
        bits = {par, d};
        @(negedge clk);
        in_data   = d;
        odd_sel   = odd;
        in_valid  = 1'b1;
        ser_ready = 1'b1;
        #1 check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        odd_sel  = ~odd;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            stall = (i == 8) ? par_len : ((i == st_bit) ? st_len : 0);
            for (int s = 0; s < stall; s++) begin
                ser_ready = 1'b0;
                #1;
                check("stall_out",   32'(ser_out),   32'(bits[i]));
                check("stall_valid", 32'(ser_valid), 32'd1);
                check("stall_ready", 32'(in_ready),  32'd0);
                @(negedge clk);
            end
            ser_ready = 1'b1;
            #1;
            check("bit",      32'(ser_out),   32'(bits[i]));
            check("valid",    32'(ser_valid), 32'd1);
            check("last",     32'(ser_last),  32'(i == 8));
            check("busy",     32'(busy),      32'd1);
            check("in_ready", 32'(in_ready),  32'(i == 8));
        end
        exp_cnt = exp_cnt + 4'd1;
        @(negedge clk);
        check("idle_valid", 32'(ser_valid), 32'd0);
        check("idle_busy",  32'(busy),      32'd0);
        check("frame_cnt",  32'(frame_cnt), 32'(exp_cnt));
    endtask

    initial begin
        logic [17:0] b2b_bits;
        logic [7:0]  wd;
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        odd_sel   = 1'b0;
        ser_ready = 1'b1;
        exp_cnt   = 4'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Even/odd parity and edge values, parity bits worked out by hand.
        run_frame(8'hA5, 1'b0, 1'b0, -1, 0, 0);
        run_frame(8'hA5, 1'b1, 1'b1, -1, 0, 0);
        run_frame(8'hFF, 1'b0, 1'b0, -1, 0, 0);
        run_frame(8'h01, 1'b0, 1'b1, -1, 0, 0);
        run_frame(8'h00, 1'b1, 1'b1, -1, 0, 0);

        // Back-to-back 3C then C3, even parity: both parities 0.
        b2b_bits = {1'b0, 8'hC3, 1'b0, 8'h3C};
        @(negedge clk);
        in_data  = 8'h3C;
        odd_sel  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_data = 8'hC3;
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            #1;
            check("b2b_bit",   32'(ser_out),   32'(b2b_bits[j]));
            check("b2b_valid", 32'(ser_valid), 32'd1);
            check("b2b_last",  32'(ser_last),  32'(j == 8 || j == 17));
            check("b2b_busy",  32'(busy),      32'd1);
            if (j == 8)
                check("b2b_ready", 32'(in_ready), 32'd1);
            if (j == 9)
                in_valid = 1'b0;
        end
        exp_cnt = exp_cnt + 4'd2;
        @(negedge clk);
        check("b2b_idle", 32'(busy),      32'd0);
        check("b2b_cnt",  32'(frame_cnt), 32'(exp_cnt));

        // Backpressure on 5A: 3-cycle stall at bit 4, 2-cycle stall at parity.
        run_frame(8'h5A, 1'b0, 1'b0, 4, 3, 2);

        // Reset mid-frame on F0 after bit 3 has been consumed.
        @(negedge clk);
        in_data  = 8'hF0;
        odd_sel  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("f0_bit", 32'(ser_out), 32'(i >= 4));
        end
        @(negedge clk);
        check("f0_bit4", 32'(ser_out), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 4'd0;
        @(negedge clk);
        check("post_rst_idle", 32'(ser_valid), 32'd0);
        run_frame(8'h0F, 1'b0, 1'b0, -1, 0, 0);
        check("post_rst_cnt", 32'(frame_cnt), 32'd1);

        // Counter wrap with a 4-bit counter: 17 frames after a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 4'd0;
        for (int k = 1; k <= 17; k++) begin
            wd = 8'(k * 37);
            run_frame(wd, k[0], (^wd) ^ k[0], -1, 0, 0);
            if (k == 15) check("wrap15", 32'(frame_cnt), 32'd15);
            if (k == 16) check("wrap16", 32'(frame_cnt), 32'd0);
            if (k == 17) check("wrap17", 32'(frame_cnt), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
